bsg_mem_1rw_sync_mask_write_bit_initiator: RTL and testbench

//  Client-side driver for bsg_mem_1rw_sync_mask_write_bit: accepts read/masked-write requests on a valid/ready port,

---
 rtl/bsg_mem_1rw_sync_mask_write_bit_initiator_pkg.sv | 11 +
 rtl/bsg_mem_1rw_sync_mask_write_bit_initiator_hold.sv | 38 +++
 rtl/bsg_mem_1rw_sync_mask_write_bit_initiator.sv | 130 +++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_initiator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator_pkg.sv
// Shared types for the 1RW mask-write RAM initiator: controller state and address sizing.
package bsg_mem_1rw_sync_mask_write_bit_initiator_pkg;

  typedef enum logic {e_init, e_ready} state_e;

  // Address width that stays at least one bit wide for a single-entry RAM.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator_hold.sv
// Read-return stage: presents RAM read data the cycle after a read and parks it
// in a one-entry register until the consumer yumis it.
module bsg_mem_1rw_sync_mask_write_bit_initiator_hold
  import bsg_mem_1rw_sync_mask_write_bit_initiator_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               rd_inflight_i,
  input  logic               yumi_i,
  input  logic [width_p-1:0] mem_data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               hold_v_q;
  logic [width_p-1:0] hold_r;
  logic               park;

  // RAM output is only guaranteed the cycle after the read, so capture it
  // whenever that cycle goes unconsumed.
  assign park = rd_inflight_i & ~yumi_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)     hold_v_q <= 1'b0;
    else if (park)   hold_v_q <= 1'b1;
    else if (yumi_i) hold_v_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (park) hold_r <= mem_data_i;
  end

  assign v_o    = rd_inflight_i | hold_v_q;
  assign data_o = hold_v_q ? hold_r : mem_data_i;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator.sv
// Client-side driver for a 1RW synchronous bit-masked RAM: clears the array after
// reset, then forwards read/write requests and returns read data on valid/yumi.
module bsg_mem_1rw_sync_mask_write_bit_initiator
  import bsg_mem_1rw_sync_mask_write_bit_initiator_pkg::*;
#(
  parameter int                 width_p       = 32,
  parameter int                 els_p         = 16,
  parameter int                 addr_width_lp = safe_clog2(els_p),
  parameter bit                 init_en_p     = 1'b1,
  parameter logic [width_p-1:0] init_val_p    = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,

  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  input  logic                     yumi_i,

  output logic                     init_done_o,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  state_e                   state_q, state_n;
  logic [addr_width_lp-1:0] cnt_q;
  logic                     in_init;
  logic                     ready;
  logic                     rd_accept;
  logic                     rd_inflight_q;

  assign in_init = (state_q == e_init);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= init_en_p ? e_init : e_ready;
    else         state_q <= state_n;
  end

  // Next state: the sweep is exactly els_p cycles, leaving on the last address
  always_comb begin
    state_n = state_q;
    case (state_q)
      e_init:  if (cnt_q == addr_width_lp'(els_p - 1)) state_n = e_ready;
      e_ready: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)      cnt_q <= '0;
    else if (in_init) cnt_q <= cnt_q + addr_width_lp'(1);
  end

  // Outputs: sweep owns the RAM port during INIT, otherwise requests pass through
  always_comb begin
    ready        = 1'b0;
    mem_v_o      = 1'b0;
    mem_w_o      = w_i;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = w_mask_i;
    if (!reset_i) begin
      if (in_init) begin
        mem_v_o      = 1'b1;
        mem_w_o      = 1'b1;
        mem_addr_o   = cnt_q;
        mem_data_o   = init_val_p;
        mem_w_mask_o = '1;
      end else begin
        ready   = ~v_o | yumi_i;
        mem_v_o = v_i & ready;
      end
    end
  end

  assign ready_o     = ready;
  assign init_done_o = (state_q == e_ready);
  assign rd_accept   = mem_v_o & ~in_init & ~w_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) rd_inflight_q <= 1'b0;
    else         rd_inflight_q <= rd_accept;
  end

  bsg_mem_1rw_sync_mask_write_bit_initiator_hold #(
    .width_p(width_p)
  ) hold (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rd_inflight_i(rd_inflight_q),
    .yumi_i       (yumi_i),
    .mem_data_i   (mem_data_i),
    .v_o          (v_o),
    .data_o       (data_o)
  );

`ifndef SYNTHESIS
  logic                     pend_q;
  logic                     pend_w_q;
  logic [addr_width_lp-1:0] pend_addr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) pend_q <= 1'b0;
    else         pend_q <= v_i & ~ready;
    pend_w_q    <= w_i;
    pend_addr_q <= addr_i;
    if (!reset_i) begin
      assert (!yumi_i || v_o)
        else $error("yumi_i asserted while v_o is low");
      if (v_i && ready)
        assert (int'(addr_i) < els_p)
          else $error("request address %0d beyond els_p", addr_i);
      if (pend_q && !(v_i && w_i == pend_w_q && addr_i == pend_addr_q))
        $warning("request withdrawn or changed before ready_o");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_initiator.sv
// Directed bench: a RAM stand-in on the mem_* port plus a queue/array model of the
// request stream, checked every cycle, with literal pins on key results.
module tb_bsg_mem_1rw_sync_mask_write_bit_initiator;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [W-1:0]  data_i = '0, w_mask_i = '0;
  logic          ready_o, v_o, init_done_o;
  logic [W-1:0]  data_o;
  logic          mem_v_o, mem_w_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o, mem_w_mask_o;
  logic [W-1:0]  mem_data_i = '0;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_bit_initiator #(
    .width_p(W), .els_p(N), .init_en_p(1'b1), .init_val_p(32'h0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .w_mask_i(w_mask_i),
    .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
    .init_done_o(init_done_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // RAM stand-in, seeded with junk so the clear sweep is observable
  logic [W-1:0] ram [N];
  logic         seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < N; i++) ram[i] <= 32'hA5A50000 | 32'(i);
      seeded <= 1'b1;
    end else if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else         mem_data_i <= ram[mem_addr_o];
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model: sweep progress, expected contents, and pending read results
  int           sw = 0;
  logic [W-1:0] exp_mem [N];
  logic [W-1:0] out_q [$];

  initial forever begin
    @(posedge clk);
    if (reset_i) begin
      sw = 0;
      out_q.delete();
    end else if (sw < N) begin
      exp_mem[sw] = 32'h0;
      sw++;
    end else begin
      logic acc;
      acc = v_i && (out_q.size() == 0 || yumi_i);
      if (yumi_i && out_q.size() > 0) void'(out_q.pop_front());
      if (acc) begin
        if (w_i) exp_mem[addr_i] = (exp_mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
        else     out_q.push_back(exp_mem[addr_i]);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_i) begin
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_mem_v", 32'(mem_v_o), 32'd0);
    end else if (sw < N) begin
      check("init_done_lo", 32'(init_done_o), 32'd0);
      check("init_ready", 32'(ready_o), 32'd0);
      check("init_v_o", 32'(v_o), 32'd0);
      check("init_mem_v", 32'(mem_v_o), 32'd1);
      check("init_mem_w", 32'(mem_w_o), 32'd1);
      check("init_addr", 32'(mem_addr_o), 32'(sw));
      check("init_data", mem_data_o, 32'h0);
      check("init_mask", mem_w_mask_o, 32'hFFFFFFFF);
    end else begin
      logic e_ready;
      e_ready = (out_q.size() == 0) || yumi_i;
      check("init_done_hi", 32'(init_done_o), 32'd1);
      check("ready", 32'(ready_o), 32'(e_ready));
      check("v_o", 32'(v_o), 32'(out_q.size() > 0));
      if (out_q.size() > 0) check("data_o", data_o, out_q[0]);
      check("mem_v", 32'(mem_v_o), 32'(v_i && e_ready));
      if (v_i && e_ready) begin
        check("mem_w", 32'(mem_w_o), 32'(w_i));
        check("mem_addr", 32'(mem_addr_o), 32'(addr_i));
        if (w_i) begin
          check("mem_data", mem_data_o, data_i);
          check("mem_mask", mem_w_mask_o, w_mask_i);
        end
      end
    end
  end

  int pulses = 0;
  always @(posedge clk) if (v_o && yumi_i) pulses <= pulses + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Call right after the edge that sampled reset high with reset_i now low
  task automatic wait_init(input string nm);
    int n = 0;
    while (!init_done_o && n < 40) begin
      cyc();
      n++;
    end
    check(nm, 32'(n), 32'd16);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
    cyc();
    v_i = 1'b0; w_i = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] exp, input string nm);
    v_i = 1'b1; w_i = 1'b0; addr_i = a;
    cyc();
    v_i = 1'b0; yumi_i = 1'b1;
    @(negedge clk);
    check({nm, "_v"}, 32'(v_o), 32'd1);
    check(nm, data_o, exp);
    cyc();
    yumi_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (2) cyc();
    reset_i = 1'b0;
    wait_init("init_len");

    do_write(4'd3, 32'hDEADBEEF, 32'hFFFFFFFF);
    do_read(4'd3, 32'hDEADBEEF, "rd_full");
    do_write(4'd3, 32'h00000000, 32'h0000FFFF);
    do_read(4'd3, 32'hDEAD0000, "rd_masked");

    // Unconsumed read: first cycle comes from the RAM, the rest from the hold register
    v_i = 1'b1; w_i = 1'b0; addr_i = 4'd3;
    cyc();
    v_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_ready", 32'(ready_o), 32'd0);
      check("hold_v", 32'(v_o), 32'd1);
      check("hold_data", data_o, 32'hDEAD0000);
      cyc();
    end
    yumi_i = 1'b1;
    @(negedge clk);
    check("hold_ready_yumi", 32'(ready_o), 32'd1);
    cyc();
    yumi_i = 1'b0;
    @(negedge clk);
    check("hold_drained", 32'(v_o), 32'd0);

    for (int i = 0; i < N; i++)
      do_write(AW'(i), 32'h01020304 * 32'(i + 1), (i % 2 == 1) ? 32'h00FFFF00 : 32'hFFFFFFFF);
    p0 = pulses;
    for (int i = 0; i < N; i++) begin
      v_i = 1'b1; w_i = 1'b0; addr_i = AW'(i); yumi_i = (i > 0);
      cyc();
    end
    v_i = 1'b0; yumi_i = 1'b1;
    cyc();
    yumi_i = 1'b0;
    check("stream_pulses", 32'(pulses - p0), 32'd16);
    do_read(4'd3, 32'hDE080C00, "pin_a3");
    do_read(4'd2, 32'h0306090C, "pin_a2");

    // Reset in the middle of the sweep
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    repeat (7) cyc();
    @(negedge clk);
    check("sweep_at7", 32'(mem_addr_o), 32'd7);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    wait_init("init_after_midreset");

    // Reset while a read is parked in the hold register
    do_write(4'd5, 32'hCAFEF00D, 32'hFFFFFFFF);
    v_i = 1'b1; w_i = 1'b0; addr_i = 4'd5;
    cyc();
    v_i = 1'b0;
    cyc();
    @(negedge clk);
    check("held_a5", data_o, 32'hCAFEF00D);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    check("v_after_rst", 32'(v_o), 32'd0);
    wait_init("init_after_held_rst");
    do_read(4'd5, 32'h00000000, "swept_a5");

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
